serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
- Downstream consumer of the N-bit shift register stage.
- Takes its serial bit stream one bit per strobe, frames it as start bit / N data bits / optional parity / stop bit, and reassembles the parallel word.
- Presents the word on a valid/ready output port with overrun and framing error flags.
- Sits between the shift stage's serial output and any parallel sink (register file, FIFO).

Parameters:
- N, 4, data bits per frame; legal range 1..32.
- MSB_FIRST, 1, 1 = first received data bit lands in Dout[N]; 0 = first bit lands in Dout[1].
- ODD_PAR, 0, parity sense when PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- CLK  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-high reset.
- Sin  input  1  serial data bit from the shift stage.
- Sin_en  input  1  bit strobe; Sin is sampled only on edges where Sin_en=1.
- Dout  output  [N:1]  assembled parallel word.
- Dvalid  output  1  Dout holds an unconsumed word.
- Drdy  input  1  sink accepts the word; transfer occurs when Dvalid&Drdy at a rising edge.
- Ferr  output  1  one-cycle pulse: stop bit sampled as 0.
- Perr  output  1  one-cycle pulse: parity mismatch.
- Ovr  output  1  sticky overrun flag.
- err_clr  input  1  synchronous clear of Ovr.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, bit counter=0, shift buffer=0, Dout=0, Dvalid=0, Ferr=0, Perr=0, Ovr=0.
  - clr asserted mid-frame aborts the frame; nothing is delivered.
- All sampling is gated by Sin_en. Cycles with Sin_en=0 change no state; only handshake and err_clr still act.
- FSM states: IDLE, DATA, PAR (present only with PARITY_EN), STOP.
- IDLE: Sin_en=1 & Sin=0 -> DATA, counter=0. Sin=1 stays IDLE (line idle high).
- DATA: each strobe shifts Sin into the internal buffer and increments the counter.
  - MSB_FIRST=1: buffer = {buf[N-1:1], Sin}.
  - MSB_FIRST=0: buffer = {Sin, buf[N:2]}.
  - After the N-th data bit (counter reaches N) -> PAR if present, else STOP.
- PAR: one strobe samples the parity bit -> STOP.
  - Mismatch is recorded internally.
  - Even parity: XOR of data bits and parity bit must be 0; odd parity: must be 1.
- STOP: one strobe samples the stop bit, then -> IDLE.
  - Sin=0: Ferr=1 for exactly one cycle; frame discarded.
  - Sin=1 with parity mismatch recorded: Perr=1 for one cycle; frame discarded.
  - Sin=1 with no mismatch: frame complete.
- Delivery on the completing edge (registered; visible the next cycle):
  - Dvalid=0: Dout<=buffer, Dvalid<=1.
  - Dvalid=1 & Drdy=1 on the same edge: old word consumed, Dout<=new word, Dvalid stays 1, no overrun.
  - Dvalid=1 & Drdy=0: new word dropped, Dout unchanged, Ovr<=1.
- Handshake:
  - Dvalid&Drdy with no completion that edge: Dvalid<=0; Dout holds its last value.
  - Dout never changes while Dvalid=1 & Drdy=0.
- Ovr:
  - Sticky; cleared only by clr or err_clr=1.
  - If err_clr and a new overrun occur on the same edge, the overrun wins (Ovr=1).
- Latency: start-bit strobe to Dvalid is N+2 strobes (N+3 with PARITY_EN), plus one register stage.
- Ferr and Perr are never high simultaneously.
- Ferr and Perr are never high in the same cycle that Dvalid rises.
- Counter width: minimum bits to hold N (N+1 states); it never wraps within a frame.

Optional Feature:
- Macro PARITY_EN.
- Defined:
  - PAR state exists; frames are N+3 bits.
  - Parity is checked per ODD_PAR; Perr is driven.
- Undefined:
  - No PAR state; frames are N+2 bits.
  - Perr is tied to 0; ODD_PAR is ignored.
  - Port list is identical in both builds.

Test Plan:
- Reset/idle: clr pulse mid-DATA, then Sin=1 strobes -> all outputs 0, state IDLE, Dvalid never rises.
- Basic frame: N=4, MSB_FIRST=1, strobes 0,1,0,1,1,1, Drdy=1 -> Dout=4'b1011, Dvalid high one cycle, then 0.
  - Same frame with MSB_FIRST=0 -> Dout=4'b1101.
- Framing error: strobes 0,1,1,0,0,0 -> Ferr one-cycle pulse on the stop edge, Dvalid stays 0, FSM returns to IDLE.
  - Next good frame with data 0110 is delivered normally.
- Overrun: Drdy=0, two good frames with data 1010 then 0101 -> Dout=4'b1010, Ovr=1.
  - err_clr=1 for one cycle -> Ovr=0 while Dout is still 1010.
- Back-to-back with simultaneous consume: second frame completes on the same edge as Dvalid&Drdy -> Dout switches 1010->0101, Dvalid stays 1, Ovr stays 0.
- PARITY_EN, ODD_PAR=0: data 1011 with parity 1 and stop 1 -> delivered.
  - Same data with parity 0 -> Perr pulse, no delivery.
  - Gaps of 3 cycles with Sin_en=0 between strobes change no results.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: deserialises a strobed start/data/[parity]/stop bit stream
// into an N-bit word presented on a valid/ready port, with framing, parity and
// sticky overrun flags.
// Build option: define PARITY_EN to add a parity bit after the data bits
// (sense set by ODD_PAR); without it Perr is tied low.
module serial_frame_rx #(
  parameter int N         = 4,
  parameter int MSB_FIRST = 1,
  parameter int ODD_PAR   = 0
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         Sin,
  input  logic         Sin_en,
  output logic [N:1]   Dout,
  output logic         Dvalid,
  input  logic         Drdy,
  output logic         Ferr,
  output logic         Perr,
  output logic         Ovr,
  input  logic         err_clr
);

  localparam int              CW   = $clog2(N + 1);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  if (N < 1 || N > 32 || MSB_FIRST < 0 || MSB_FIRST > 1 || ODD_PAR < 0 || ODD_PAR > 1)
  begin : g_bad_param
    $error("serial_frame_rx: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
`ifdef PARITY_EN
    PAR  = 2'd2,
`endif
    STOP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:1]    buf_q, buf_d;
  logic [N:1]    dout_q, dout_d;
  logic          dvalid_q, dvalid_d;
  logic          ferr_q, ferr_d;
  logic          perr_q, perr_d;
  logic          ovr_q, ovr_d;
  logic [N:1]    shifted;
  logic          done;
`ifdef PARITY_EN
  logic          par_acc_q, par_acc_d;
  logic          par_bad_q, par_bad_d;
`endif

  // Next buffer value when a data bit is shifted in
  if (N == 1) begin : g_shift_one
    always_comb shifted = Sin;
  end else if (MSB_FIRST != 0) begin : g_shift_msb
    always_comb shifted = {buf_q[N-1:1], Sin};
  end else begin : g_shift_lsb
    always_comb shifted = {Sin, buf_q[N:2]};
  end

  // Frame sequencing, delivery handshake and error flags
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ferr_d   = 1'b0;
    perr_d   = 1'b0;
    ovr_d    = err_clr ? 1'b0 : ovr_q;
    done     = 1'b0;
`ifdef PARITY_EN
    par_acc_d = par_acc_q;
    par_bad_d = par_bad_q;
`endif
    if (Sin_en) begin
      unique case (state_q)
        IDLE: begin
          if (!Sin) begin
            state_d = DATA;
            cnt_d   = '0;
`ifdef PARITY_EN
            par_acc_d = 1'b0;
            par_bad_d = 1'b0;
`endif
          end
        end
        DATA: begin
          buf_d = shifted;
          cnt_d = cnt_q + CW'(1);
`ifdef PARITY_EN
          par_acc_d = par_acc_q ^ Sin;
          if (cnt_q == LAST) state_d = PAR;
`else
          if (cnt_q == LAST) state_d = STOP;
`endif
        end
`ifdef PARITY_EN
        PAR: begin
          par_bad_d = ((par_acc_q ^ Sin) != (ODD_PAR != 0));
          state_d   = STOP;
        end
`endif
        STOP: begin
          state_d = IDLE;
          if (!Sin) begin
            ferr_d = 1'b1;
`ifdef PARITY_EN
          end else if (par_bad_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            done = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // A completing frame may replace a word being consumed on the same edge;
    // otherwise it is dropped and the overrun (which beats err_clr) is flagged.
    if (done) begin
      if (!dvalid_q || Drdy) begin
        dout_d   = buf_q;
        dvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (dvalid_q && Drdy) begin
      dvalid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      buf_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef PARITY_EN
      par_acc_q <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      ovr_q    <= ovr_d;
`ifdef PARITY_EN
      par_acc_q <= par_acc_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign Dout   = dout_q;
  assign Dvalid = dvalid_q;
  assign Ferr   = ferr_q;
  assign Perr   = perr_q;
  assign Ovr    = ovr_q;

endmodule
